// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int SEC_LIMIT         = 59;
    localparam int MIN_LIMIT_DEFAULT = 99;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter 00..LIMIT with synchronous clear; wrap flags the LIMIT -> 00 step.
module bcd2_counter #(
    parameter int LIMIT = 99
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    localparam logic [3:0] LIM_TENS = 4'(LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(LIMIT % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_limit;

    assign at_limit = (tens_q == LIM_TENS) && (ones_q == LIM_ONES);
    assign wrap     = inc & at_limit;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            if (at_limit) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tens_q <= tens_d;
        ones_q <= ones_d;
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch: counts MM:SS on the 1 Hz tick, pause toggle, and a 2 Hz field-adjust mode with blink.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = MIN_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz_tick,
    input  logic       two_hz_tick,
    input  logic       four_hz_tick,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blink_min,
    output logic       blink_sec,
    output logic       running
);

    state_t state_q, state_d;
    logic   paused_flag_q, paused_flag_d;
    logic   phase_q, phase_d;
    logic   blink_min_q, blink_min_d;
    logic   blink_sec_q, blink_sec_d;
    logic   running_q, running_d;

    logic in_run, in_adj, sec_inc, min_inc, sec_wrap;

    assign in_run = (state_q == ST_RUN);
    assign in_adj = (state_q == ST_ADJUST);

    // Carry into minutes only in RUN; adjust edits one field at a time.
    assign sec_inc = (in_run & one_hz_tick) | (in_adj & two_hz_tick & sel);
    assign min_inc = (in_run & one_hz_tick & sec_wrap) | (in_adj & two_hz_tick & ~sel);

    bcd2_counter #(.LIMIT(SEC_LIMIT)) u_sec (
        .clk  (clk),
        .clr  (rst),
        .inc  (sec_inc),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    logic min_wrap_unused;

    bcd2_counter #(.LIMIT(MIN_LIMIT)) u_min (
        .clk  (clk),
        .clr  (rst),
        .inc  (min_inc),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap_unused)
    );

    always_comb begin
        state_d       = state_q;
        paused_flag_d = paused_flag_q;
        unique case (state_q)
            ST_RUN: begin
                if (adj) begin
                    state_d       = ST_ADJUST;
                    paused_flag_d = 1'b0;
                end else if (pause_btn) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj) begin
                    state_d       = ST_ADJUST;
                    paused_flag_d = 1'b1;
                end else if (pause_btn) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (pause_btn) paused_flag_d = ~paused_flag_q;
                if (!adj) state_d = paused_flag_q ? ST_PAUSED : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Phase only lives inside ADJUST, so it is zero on the entry cycle.
        phase_d     = in_adj ? (phase_q ^ four_hz_tick) : 1'b0;
        blink_min_d = (state_d == ST_ADJUST) & ~sel & phase_d;
        blink_sec_d = (state_d == ST_ADJUST) & sel & phase_d;
        running_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            paused_flag_q <= 1'b0;
            phase_q       <= 1'b0;
            blink_min_q   <= 1'b0;
            blink_sec_q   <= 1'b0;
            running_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            paused_flag_q <= paused_flag_d;
            phase_q       <= phase_d;
            blink_min_q   <= blink_min_d;
            blink_sec_q   <= blink_sec_d;
            running_q     <= running_d;
        end
    end

    assign blink_min = blink_min_q;
    assign blink_sec = blink_sec_q;
    assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: vector table, directed corner sequences, and random stimulus vs a reference model.
module tb_stopwatch_counter;

    localparam int MIN_LIMIT = 99;
    localparam int M_RUN = 0, M_PAUSED = 1, M_ADJ = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_hz_tick = 1'b0, two_hz_tick = 1'b0, four_hz_tick = 1'b0;
    logic       pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blink_min, blink_sec, running;

    int checks   = 0;
    int failures = 0;

    int m_mode, m_flag, m_phase, m_min, m_sec;

    stopwatch_counter #(.MIN_LIMIT(MIN_LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .one_hz_tick  (one_hz_tick),
        .two_hz_tick  (two_hz_tick),
        .four_hz_tick (four_hz_tick),
        .pause_btn    (pause_btn),
        .adj          (adj),
        .sel          (sel),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .blink_min    (blink_min),
        .blink_sec    (blink_sec),
        .running      (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_min();
        return int'(min_tens) * 10 + int'(min_ones);
    endfunction

    function automatic int dut_sec();
        return int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    // Reference: whole minutes/seconds as integers, modes as small ints.
    task automatic model_step();
        int nm;
        if (rst) begin
            m_mode = M_RUN; m_flag = 0; m_phase = 0; m_min = 0; m_sec = 0;
            return;
        end
        nm = m_mode;
        case (m_mode)
            M_RUN: begin
                if (one_hz_tick) begin
                    m_sec = m_sec + 1;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min = (m_min == MIN_LIMIT) ? 0 : m_min + 1;
                    end
                end
                if (adj) begin nm = M_ADJ; m_flag = 0; end
                else if (pause_btn) nm = M_PAUSED;
            end
            M_PAUSED: begin
                if (adj) begin nm = M_ADJ; m_flag = 1; end
                else if (pause_btn) nm = M_RUN;
            end
            default: begin
                if (two_hz_tick) begin
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min + 1) % (MIN_LIMIT + 1);
                end
                if (!adj) nm = (m_flag != 0) ? M_PAUSED : M_RUN;
                if (pause_btn) m_flag = 1 - m_flag;
            end
        endcase
        m_phase = (m_mode == M_ADJ) ? (m_phase ^ int'(four_hz_tick)) : 0;
        m_mode  = nm;
    endtask

    task automatic model_cmp();
        chk("m_min_tens", int'(min_tens), m_min / 10);
        chk("m_min_ones", int'(min_ones), m_min % 10);
        chk("m_sec_tens", int'(sec_tens), m_sec / 10);
        chk("m_sec_ones", int'(sec_ones), m_sec % 10);
        chk("m_running", int'(running), int'(m_mode == M_RUN));
        chk("m_blink_min", int'(blink_min), int'(m_mode == M_ADJ && !sel && m_phase != 0));
        chk("m_blink_sec", int'(blink_sec), int'(m_mode == M_ADJ && sel && m_phase != 0));
    endtask

    task automatic cyc(input logic r, input logic o, input logic t, input logic f,
                       input logic p, input logic a, input logic s);
        rst = r; one_hz_tick = o; two_hz_tick = t; four_hz_tick = f;
        pause_btn = p; adj = a; sel = s;
        model_step();
        @(posedge clk);
        #1;
        rst = 1'b0; one_hz_tick = 1'b0; two_hz_tick = 1'b0; four_hz_tick = 1'b0; pause_btn = 1'b0;
        model_cmp();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic r, o, t, f, p, a, s;
        int   mm, ss;
        logic run, bm, bs;
    } vec_t;

    vec_t vecs[19];

    initial begin
        //             r  o  t  f  p  a  s   mm ss run bm bs
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 0,  0, 2, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0,  0, 2, 1, 0, 0};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 0,  0, 3, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 1, 1,  0, 3, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 1, 1,  0, 3, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 1, 1,  0, 4, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 0, 1, 0,  1, 4, 0, 0, 0};
        vecs[12] = '{0, 1, 1, 0, 0, 1, 0,  2, 4, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0,  2, 4, 1, 0, 0};
        vecs[14] = '{0, 1, 0, 0, 0, 0, 0,  2, 5, 1, 0, 0};
        vecs[15] = '{0, 0, 0, 1, 0, 1, 0,  2, 5, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 1, 0, 1, 0,  2, 5, 0, 1, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 1, 1,  2, 5, 0, 0, 1};
        vecs[18] = '{0, 0, 0, 0, 0, 0, 1,  2, 5, 1, 0, 0};

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].r, vecs[i].o, vecs[i].t, vecs[i].f, vecs[i].p, vecs[i].a, vecs[i].s);
            chk($sformatf("vec%0d_min", i), dut_min(), vecs[i].mm);
            chk($sformatf("vec%0d_sec", i), dut_sec(), vecs[i].ss);
            chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].run));
            chk($sformatf("vec%0d_blink_min", i), int'(blink_min), int'(vecs[i].bm));
            chk($sformatf("vec%0d_blink_sec", i), int'(blink_sec), int'(vecs[i].bs));
        end

        // 60 ticks from reset roll into the first minute
        cyc(1, 0, 0, 0, 0, 0, 0);
        ticks(60);
        chk("sixty_min", dut_min(), 1);
        chk("sixty_sec", dut_sec(), 0);
        chk("sixty_running", int'(running), 1);
        chk("sixty_blinks", int'({blink_min, blink_sec}), 0);

        // Preload 99:59 through adjust, then one tick wraps everything
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 99; i++) cyc(0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0, 1, 1);
        chk("preload_min", dut_min(), 99);
        chk("preload_sec", dut_sec(), 59);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("preload_running", int'(running), 1);
        ticks(1);
        chk("wrap_min", dut_min(), 0);
        chk("wrap_sec", dut_sec(), 0);

        // Pause / resume from 00:10
        cyc(1, 0, 0, 0, 0, 0, 0);
        ticks(10);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("pause_running", int'(running), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            chk("paused_sec", dut_sec(), 10);
            chk("paused_running", int'(running), 0);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("resume_running", int'(running), 1);
        ticks(3);
        chk("resume_sec", dut_sec(), 13);
        chk("resume_min", dut_min(), 0);

        // Adjust from 00:58: seconds wrap without carry, then minutes
        cyc(1, 0, 0, 0, 0, 0, 0);
        ticks(58);
        cyc(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1, 1);
        chk("adj_sec", dut_sec(), 1);
        chk("adj_min_hold", dut_min(), 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        chk("adj_min", dut_min(), 1);
        chk("adj_sec_hold", dut_sec(), 1);

        // Blink pattern on minutes field
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("blink_entry", int'(blink_min), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 1, 0);
            chk($sformatf("blink_min_%0d", i), int'(blink_min), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("blink_sec_%0d", i), int'(blink_sec), 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("blink_exit", int'({blink_min, blink_sec}), 0);

        // Pause together with tick at 00:05
        cyc(1, 0, 0, 0, 0, 0, 0);
        ticks(5);
        cyc(0, 1, 0, 0, 1, 0, 0);
        chk("same_cycle_sec", dut_sec(), 6);
        chk("same_cycle_running", int'(running), 0);
        ticks(1);
        chk("same_cycle_hold", dut_sec(), 6);

        // Random stimulus against the reference model
        cyc(1, 0, 0, 0, 0, 0, 0);
        begin
            logic a_lvl = 1'b0, s_lvl = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) a_lvl = ~a_lvl;
                if ($urandom_range(7) == 0)  s_lvl = ~s_lvl;
                cyc(logic'($urandom_range(99) == 0),
                    logic'($urandom_range(2) == 0),
                    logic'($urandom_range(2) == 0),
                    logic'($urandom_range(2) == 0),
                    logic'($urandom_range(9) == 0),
                    a_lvl, s_lvl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
